y86_mem_stage_pipe: RTL
=======================

Name: y86_mem_stage_pipe

Overview:
Parametrised successor to the pipeline Memory stage of the Y86-64 pipe. Performs data-memory reads and writes for rmmovq, mrmovq, call, ret, pushq and popq, and registers the M->W pipeline outputs. New relative to the current stage: configurable access latency with a stall handshake, registered outputs, a synchronous reset, and bounds checking that rewrites the status to SADR. After any exception, all further memory writes are suppressed.

Parameters:
DATA_W, 64, width of valE/valA/valM and of one memory word
MEM_WORDS, 2048, memory depth in words; an address is a word index
LAT, 1, access latency in cycles for in-bounds memory ops; legal values are 1..15
CNT_W, 4, width of the latency counter; must hold LAT

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
M_valid  in  1  M register holds an instruction this cycle
M_stat  in  4  incoming status (SAOK=1, SHLT=2, SADR=3, SINS=4)
M_icode  in  4  incoming icode
M_valE  in  DATA_W  ALU result / address for rmmovq, mrmovq, call, pushq
M_valA  in  DATA_W  write data; address for ret and popq
M_dstE  in  4  dest reg E
M_dstM  in  4  dest reg M
mem_stall  out  1  combinational; upstream must hold M_* stable while 1
m_valid  out  1  registered; outputs below hold a completed instruction
m_stat  out  4  registered status
m_icode  out  4  registered icode
m_valE  out  DATA_W  registered valE
m_valM  out  DATA_W  registered read data
m_dstE  out  4  registered dstE
m_dstM  out  4  registered dstM
DataMemError  out  1  registered; 1 for the output cycle of an out-of-bounds op

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, cnt=0, halted=0, m_valid=0, m_stat=SAOK, m_icode=NOP(1), m_valE=0, m_valM=0, m_dstE=m_dstM=RNONE(F), DataMemError=0.
- Reset does not clear the memory array.
- Reset during BUSY aborts the op; its write is never performed.
- Op classes:
  - Write ops: rmmovq(4), call(8), pushq(A); address = M_valE, data = M_valA.
  - Read ops: mrmovq(5) uses address M_valE; ret(9) and popq(B) use address M_valA.
  - All other icodes are non-memory ops.
- Address is out of bounds iff address >= MEM_WORDS (full DATA_W compare, unsigned).
- Every instruction produces exactly one m_valid=1 cycle. A cycle with M_valid=0 and no completion produces m_valid=0, and the other outputs keep their values.
- Single-cycle completion (no stall) applies to:
  - non-memory ops;
  - ops with M_stat != SAOK;
  - out-of-bounds ops;
  - all ops when LAT=1.
- Completion effects: outputs register M_* on the accepting edge. Write ops write on that edge. Read ops set m_valM = mem[addr]; otherwise m_valM=0.
- States: IDLE, BUSY.
- IDLE, accepting an in-bounds memory op with M_stat=SAOK and LAT>1:
  - mem_stall=1 combinationally.
  - Next edge: state=BUSY, cnt=LAT-1, m_valid=0.
- BUSY:
  - mem_stall = (cnt != 1).
  - Each edge decrements cnt.
  - At the edge where cnt==1: perform the write or read, register outputs with m_valid=1, return to IDLE.
- The cycle after completion, a new op is accepted in IDLE. Back-to-back ops therefore take LAT cycles each.
- Out-of-bounds: no write. m_stat=SADR, m_valM=0, DataMemError=1 for that output cycle, and halted is set. Other fields pass through unchanged.
- halted is also set when an op with M_stat in {SHLT, SADR, SINS} completes.
- While halted=1, writes are suppressed. Reads, status and stat pass-through continue. Only rst clears halted.
- An op with M_stat != SAOK never accesses memory. Its m_stat = M_stat unchanged.
- Read of a word written by the immediately preceding op returns the new data, because the write lands at the earlier edge.
- Reads of never-written words are undefined. The bench must initialise before reading.

Decomposition:
- Package y86_pkg:
  - icode constants (NOP, RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ);
  - stat codes SAOK/SHLT/SADR/SINS;
  - RNONE;
  - state enum {IDLE, BUSY}.
- Sub-module y86_dmem holds the word array:
  - parameters DATA_W, MEM_WORDS;
  - synchronous write with enable;
  - asynchronous read;
  - addr width $clog2(MEM_WORDS).
- The top level owns the FSM, the counter, the bounds check, halted and the output registers.

Test Plan:
- LAT=1: rmmovq valE=5, valA=0x1234, then mrmovq valE=5 -> second op has m_valM=0x1234, m_valid=1 each cycle, mem_stall never 1.
- LAT=3: pushq valE=10, valA=77 -> mem_stall=1 for 2 cycles; m_valid=1 exactly on the 3rd edge; popq valA=10 -> m_valM=77 after 3 cycles.
- rmmovq valE=2048 (MEM_WORDS=2048), valA=9 -> same-cycle m_stat=SADR, DataMemError=1, no stall. Then rmmovq valE=3, valA=9 -> mem[3] unchanged (halted); then rst -> rmmovq valE=3 writes 9.
- M_stat=SINS with icode rmmovq valE=4, valA=55 -> no write, m_stat=SINS, m_valid=1 next edge, halted set.
- LAT=4: assert rst in the 2nd BUSY cycle of rmmovq valE=6, valA=0xAA -> outputs at reset values next cycle; mem[6] keeps its prior value; state IDLE.
- Non-memory op (OPq, icode 6, valE=42, dstE=3) -> m_valE=42, m_dstE=3, m_valM=0, 1-cycle latency for any LAT.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 pipelined memory stage: icodes, status
// codes, the "no register" id and the stage FSM states.
package y86_pkg;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/y86_dmem.sv
// Word-addressed data memory: synchronous write with enable, asynchronous read.
module y86_dmem #(
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 2048,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/y86_mem_stage_pipe.sv
// Y86-64 Memory stage with configurable access latency, stall handshake,
// bounds checking and registered M->W outputs.
module y86_mem_stage_pipe
    import y86_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 2048,
    parameter int LAT       = 1,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_valid,
    input  logic [3:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    output logic              mem_stall,
    output logic              m_valid,
    output logic [3:0]        m_stat,
    output logic [3:0]        m_icode,
    output logic [DATA_W-1:0] m_valE,
    output logic [DATA_W-1:0] m_valM,
    output logic [3:0]        m_dstE,
    output logic [3:0]        m_dstM,
    output logic              DataMemError,
    output logic              dbg_state_o
);

    localparam int                AW        = $clog2(MEM_WORDS);
    localparam logic [DATA_W-1:0] MEM_LIMIT = DATA_W'(MEM_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam bit                MULTI     = (LAT > 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              halted_q;

    logic              is_write, is_read, is_mem, stat_ok, oob;
    logic              oob_hit, long_op, complete, do_access, we;
    logic [DATA_W-1:0] addr, rdata;

    // Decode: ret/popq address through valA, everything else through valE.
    always_comb begin
        is_write = (M_icode == I_RMMOVQ) || (M_icode == I_CALL) || (M_icode == I_PUSHQ);
        is_read  = (M_icode == I_MRMOVQ) || (M_icode == I_RET)  || (M_icode == I_POPQ);
        is_mem   = is_write || is_read;
        stat_ok  = (M_stat == SAOK);
        addr     = ((M_icode == I_RET) || (M_icode == I_POPQ)) ? M_valA : M_valE;
        oob      = (addr >= MEM_LIMIT);
        oob_hit  = M_valid && is_mem && stat_ok && oob;
        long_op  = MULTI && M_valid && is_mem && stat_ok && !oob;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (long_op) state_d = BUSY;
            BUSY:    if (cnt_q == CNT_ONE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                mem_stall = long_op;
                complete  = M_valid && !long_op;
            end
            BUSY: begin
                mem_stall = (cnt_q != CNT_ONE);
                complete  = (cnt_q == CNT_ONE);
            end
            default: ;
        endcase
    end

    assign dbg_state_o = (state_q == BUSY);

    always_ff @(posedge clk) begin
        if (rst)                                cnt_q <= '0;
        else if (state_q == IDLE && long_op)    cnt_q <= CNT_LOAD;
        else if (state_q == BUSY)               cnt_q <= cnt_q - CNT_ONE;
    end

    // A reset landing on the completion edge must still cancel the write.
    assign do_access = complete && is_mem && stat_ok && !oob;
    assign we        = do_access && is_write && !halted_q && !rst;

    y86_dmem #(
        .DATA_W   (DATA_W),
        .MEM_WORDS(MEM_WORDS),
        .AW       (AW)
    ) u_dmem (
        .clk  (clk),
        .we   (we),
        .addr (addr[AW-1:0]),
        .wdata(M_valA),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid      <= 1'b0;
            m_stat       <= SAOK;
            m_icode      <= I_NOP;
            m_valE       <= '0;
            m_valM       <= '0;
            m_dstE       <= RNONE;
            m_dstM       <= RNONE;
            DataMemError <= 1'b0;
            halted_q     <= 1'b0;
        end else if (complete) begin
            m_valid      <= 1'b1;
            m_stat       <= oob_hit ? SADR : M_stat;
            m_icode      <= M_icode;
            m_valE       <= M_valE;
            m_valM       <= (do_access && is_read) ? rdata : '0;
            m_dstE       <= M_dstE;
            m_dstM       <= M_dstM;
            DataMemError <= oob_hit;
            halted_q     <= halted_q || oob_hit || (M_stat == SHLT) ||
                            (M_stat == SADR) || (M_stat == SINS);
        end else begin
            m_valid      <= 1'b0;
            DataMemError <= 1'b0;
        end
    end

endmodule
